// File: rtl/onehot_dec_pkg.sv
// Shared mode encoding and one-hot helper for the sequential
// one-hot decoder and related select-generation blocks.
package onehot_dec_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,
        MODE_GRAY = 2'b01,
        MODE_SCAN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    // Widest supported index is 8 bits; callers cast down to 2**IN_W.
    function automatic logic [255:0] onehot(input logic [7:0] idx);
        logic [255:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the
// XOR of all Gray bits at or above its position.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with binary, Gray and prescaled scan
// modes; out is always zero or exactly 1 << idx.
module onehot_decoder_seq
    import onehot_dec_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int SCAN_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in,
    output logic [2**IN_W-1:0]   out,
    output logic [IN_W-1:0]      idx,
    output logic                 out_valid,
    output logic                 wrap
);

    localparam int OUT_W = 2**IN_W;
    localparam int PW    = $clog2(SCAN_DIV) + 1;
    localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

    logic [IN_W-1:0]  bin_in;
    logic [IN_W-1:0]  idx_q, idx_d, idx_inc;
    logic [OUT_W-1:0] out_q, out_d, oh;
    logic             vld_q, vld_d;
    logic             wrap_q, wrap_d;
    logic [PW-1:0]    cnt_q, cnt_d, cnt_eff;
    mode_e            mode_q, mode_d, mode_s;
    logic             upd;

    gray_to_bin #(.W(IN_W)) u_g2b (
        .gray_i (in),
        .bin_o  (bin_in)
    );

    assign oh = OUT_W'(onehot(8'(idx_d)));

    always_comb begin
        mode_s  = mode_e'(mode);
        idx_inc = idx_q + IN_W'(1);
        idx_d   = idx_q;
        out_d   = out_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        upd     = 1'b0;
        // A fresh entry into SCAN restarts the prescale from zero.
        cnt_eff = (mode_q == MODE_SCAN) ? cnt_q : '0;
        if (en) begin
            mode_d = mode_s;
            cnt_d  = '0;
            unique case (mode_s)
                MODE_BIN: begin
                    if (in_valid) begin
                        idx_d = in;
                        upd   = 1'b1;
                    end
                end
                MODE_GRAY: begin
                    if (in_valid) begin
                        idx_d = bin_in;
                        upd   = 1'b1;
                    end
                end
                MODE_SCAN: begin
                    if (cnt_eff == TC) begin
                        idx_d  = idx_inc;
                        upd    = 1'b1;
                        wrap_d = &idx_q;
                    end else begin
                        cnt_d = cnt_eff + PW'(1);
                    end
                end
                default: ;
            endcase
        end
        if (upd) out_d = oh;
        vld_d = upd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= MODE_BIN;
        end else begin
            idx_q  <= idx_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign out       = out_q;
    assign idx       = idx_q;
    assign out_valid = vld_q;
    assign wrap      = wrap_q;

endmodule
